spiflash_reader: RTL

- Synthesizable single-bit SPI flash read initiator, the host side of the SoC's SPI flash interface.
- Accepts 32-bit word read requests on a valid/ready memory port and issues 0xAB (release power-down) once after reset.
- Serves each request with a 0x03 read command, 24-bit address and 4 data bytes, assembled little-endian.
- Can keep CS low to stream sequential words without re-issuing the command.

---
 rtl/spiflash_reader_if.sv | 10 +
 rtl/spiflash_reader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_reader_if.sv
// rtl/spiflash_reader_if.sv - word read request/response bundle for spiflash_reader
interface spiflash_reader_if;
  logic        valid;
  logic [23:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, output addr, input ready, input rdata);
  modport slave  (input valid, input addr, output ready, output rdata);
endinterface

// File: rtl/spiflash_reader.sv
// rtl/spiflash_reader.sv - single-bit SPI flash read initiator (0xAB wake, 0x03 reads, sequential continuation)
module spiflash_reader #(
  parameter int CLKDIV      = 1,
  parameter int CSH         = 4,
  parameter bit ENABLE_CONT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  spiflash_reader_if.slave mem,
  output logic             flash_csb,
  output logic             flash_clk,
  output logic             flash_io0_oe,
  output logic             flash_io0_do,
  input  logic             flash_io1_di
);

  typedef enum logic [2:0] {
    S_PWR_CSH, S_PWR_CMD, S_CSH_WAIT, S_IDLE, S_CMD, S_ADDR, S_DATA, S_CONT
  } state_t;

  localparam logic [15:0] DIV_LOAD = 16'(CLKDIV - 1);
  localparam logic [15:0] CSH_LOAD = (CSH > 0) ? 16'(CSH - 1) : 16'd0;

  state_t      r_state, w_state;
  logic [15:0] r_cnt, w_cnt;
  logic [15:0] r_div, w_div;
  logic [5:0]  r_bits, w_bits;
  logic [31:0] r_tx, w_tx;
  logic [31:0] r_rx, w_rx;
  logic        r_sck, w_sck;
  logic        r_csb, w_csb;
  logic        r_oe, w_oe;
  logic        r_do, w_do;
  logic        r_ready, w_ready;
  logic [31:0] r_rdata, w_rdata;
  logic [23:0] r_addr, w_addr;
  logic [23:0] r_next_addr, w_next_addr;
  logic        r_keep, w_keep;

  logic [23:0] w_req_addr;
  logic        w_phase_end;
  logic        w_last_bit;
  logic        w_shifting;
  logic        w_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_PWR_CSH;
      r_cnt       <= CSH_LOAD;
      r_div       <= DIV_LOAD;
      r_bits      <= 6'd0;
      r_tx        <= 32'd0;
      r_rx        <= 32'd0;
      r_sck       <= 1'b0;
      r_csb       <= 1'b1;
      r_oe        <= 1'b0;
      r_do        <= 1'b0;
      r_ready     <= 1'b0;
      r_rdata     <= 32'd0;
      r_addr      <= 24'd0;
      r_next_addr <= 24'd0;
      r_keep      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_div       <= w_div;
      r_bits      <= w_bits;
      r_tx        <= w_tx;
      r_rx        <= w_rx;
      r_sck       <= w_sck;
      r_csb       <= w_csb;
      r_oe        <= w_oe;
      r_do        <= w_do;
      r_ready     <= w_ready;
      r_rdata     <= w_rdata;
      r_addr      <= w_addr;
      r_next_addr <= w_next_addr;
      r_keep      <= w_keep;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_div       = r_div;
    w_bits      = r_bits;
    w_tx        = r_tx;
    w_rx        = r_rx;
    w_sck       = r_sck;
    w_csb       = r_csb;
    w_oe        = r_oe;
    w_do        = r_do;
    w_ready     = 1'b0;
    w_rdata     = r_rdata;
    w_addr      = r_addr;
    w_next_addr = r_next_addr;
    w_keep      = r_keep;

    w_req_addr  = mem.addr & 24'hFF_FFFC;
    w_phase_end = (r_div == 16'd0);
    w_last_bit  = w_phase_end && r_sck && (r_bits == 6'd1);
    w_accept    = mem.valid && !r_ready;
    w_shifting  = (r_state == S_PWR_CMD) || (r_state == S_CMD) || (r_state == S_ADDR) ||
                  ((r_state == S_DATA) && (r_bits != 6'd0));

    // Bit engine: MISO sampled and MOSI advanced on the edge that drops SCK.
    if (w_shifting) begin
      if (!w_phase_end) begin
        w_div = r_div - 16'd1;
      end else begin
        w_div = DIV_LOAD;
        w_sck = !r_sck;
        if (r_sck) begin
          w_rx   = {r_rx[30:0], flash_io1_di};
          w_tx   = {r_tx[30:0], 1'b0};
          w_do   = r_tx[30];
          w_bits = r_bits - 6'd1;
        end
      end
      if (!mem.valid) w_keep = 1'b0;
    end

    case (r_state)
      S_PWR_CSH: begin
        if (r_cnt == 16'd0) begin
          w_state = S_PWR_CMD;
          w_csb   = 1'b0;
          w_oe    = 1'b1;
          w_tx    = {8'hAB, 24'd0};
          w_do    = 1'b1;
          w_bits  = 6'd8;
          w_div   = DIV_LOAD;
        end else begin
          w_cnt = r_cnt - 16'd1;
        end
      end
      S_PWR_CMD: begin
        if (w_last_bit) begin
          w_state = S_CSH_WAIT;
          w_csb   = 1'b1;
          w_oe    = 1'b0;
          w_do    = 1'b0;
          w_cnt   = CSH_LOAD;
        end
      end
      S_CSH_WAIT: begin
        if (r_cnt == 16'd0) w_state = S_IDLE;
        else                w_cnt   = r_cnt - 16'd1;
      end
      S_IDLE: begin
        if (w_accept) begin
          w_state = S_CMD;
          w_addr  = w_req_addr;
          w_csb   = 1'b0;
          w_oe    = 1'b1;
          w_tx    = {8'h03, 24'd0};
          w_do    = 1'b0;
          w_bits  = 6'd8;
          w_div   = DIV_LOAD;
          w_sck   = 1'b0;
          w_keep  = 1'b1;
        end
      end
      S_CMD: begin
        if (w_last_bit) begin
          w_state = S_ADDR;
          w_tx    = {r_addr, 8'd0};
          w_do    = r_addr[23];
          w_bits  = 6'd24;
        end
      end
      S_ADDR: begin
        if (w_last_bit) begin
          w_state = S_DATA;
          w_oe    = 1'b0;
          w_do    = 1'b0;
          w_bits  = 6'd32;
        end
      end
      S_DATA: begin
        // First byte on the wire is the byte at addr, so reverse byte order.
        if (r_bits == 6'd0) begin
          w_next_addr = r_addr + 24'd4;
          if (r_keep && mem.valid) begin
            w_ready = 1'b1;
            w_rdata = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
          end
          if (ENABLE_CONT) begin
            w_state = S_CONT;
          end else begin
            w_state = S_CSH_WAIT;
            w_csb   = 1'b1;
            w_cnt   = CSH_LOAD;
          end
        end
      end
      S_CONT: begin
        if (w_accept) begin
          if (w_req_addr == r_next_addr) begin
            w_state = S_DATA;
            w_addr  = w_req_addr;
            w_bits  = 6'd32;
            w_div   = DIV_LOAD;
            w_keep  = 1'b1;
          end else begin
            w_state = S_CSH_WAIT;
            w_csb   = 1'b1;
            w_cnt   = CSH_LOAD;
          end
        end
      end
      default: w_state = S_PWR_CSH;
    endcase
  end

  assign flash_csb    = r_csb;
  assign flash_clk    = r_sck;
  assign flash_io0_oe = r_oe;
  assign flash_io0_do = r_do;
  assign mem.ready    = r_ready;
  assign mem.rdata    = r_rdata;

endmodule
